// File: rtl/fifo_rd_prefetch.sv
// Read-side unloader: pops the FIFO, captures RAM data a cycle later and
// presents it as a valid/ready stream through a 3-entry prefetch buffer.
module fifo_rd_prefetch #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LVL_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_empty,
  output logic                  o_pop,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [LVL_WIDTH-1:0]  o_level
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned IW    = 2;

  logic [IW-1:0]         occ;
  logic [IW-1:0]         head;
  logic [IW-1:0]         tail;
  logic                  infl;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] head_data;
  logic                  deq;

  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    return (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
  endfunction

  // Pop only when the word (plus any in flight) is guaranteed a buffer slot
  always_comb begin
    o_pop   = !i_rst && !i_flush && !i_empty &&
              ((3'(occ) + 3'(infl)) < 3'(DEPTH));
    o_valid = !i_rst && !i_flush && (occ != '0);
    deq     = o_valid && i_ready;
    o_level = i_rst ? '0 : LVL_WIDTH'(occ);
  end

  always_comb begin
    head_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (head == IW'(i)) head_data = mem[i];
    end
    o_data = i_rst ? '0 : head_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      occ  <= '0;
      infl <= 1'b0;
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      // Read pointer is not rewound: in-flight and buffered words are dropped
      occ  <= '0;
      infl <= 1'b0;
      head <= '0;
      tail <= '0;
    end else begin
      infl <= o_pop;
      if (infl) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (tail == IW'(i)) mem[i] <= i_rdata;
        end
        tail <= idx_inc(tail);
      end
      if (deq) head <= idx_inc(head);
      case ({infl, deq})
        2'b10:   occ <= occ + IW'(1);
        2'b01:   occ <= occ - IW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Randomized bench for fifo_rd_prefetch against a queue-based model of the
// words popped from the FIFO and their pop-to-visible latency.
module tb_fifo_rd_prefetch;

  localparam int unsigned DW     = 8;
  localparam int unsigned NCYC   = 3000;

  logic          clk;
  logic          rst;
  logic          empty;
  logic          pop;
  logic [DW-1:0] rdata;
  logic          flush;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [1:0]    level;

  fifo_rd_prefetch #(.DATA_WIDTH(DW), .LVL_WIDTH(2)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_empty (empty),
    .o_pop   (pop),
    .i_rdata (rdata),
    .i_flush (flush),
    .o_valid (valid),
    .i_ready (ready),
    .o_data  (data),
    .o_level (level)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] src[$];
  int            n_chk;
  int            n_pass;
  int            cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur, obs, exp);
  endtask

  initial begin
    logic [DW-1:0] next_word;
    logic          pend_v;
    logic [DW-1:0] pend_d;
    logic          force_empty;
    logic          exp_pop;
    logic          exp_valid;
    int            avail;
    int            phase;

    n_chk = 0; n_pass = 0; cur = 0;
    next_word = 8'h10;
    pend_v = 1'b0; pend_d = '0;
    rst = 1'b1; flush = 1'b0; empty = 1'b0; ready = 1'b0; rdata = 8'hFF;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cur = c;
      while (src.size() < 6) begin
        src.push_back(next_word);
        next_word = next_word + 8'd1;
      end
      phase = (c / 200) % 4;
      force_empty = 1'b0;
      if (c < 3) begin
        rst = 1'b1; flush = 1'b0; ready = 1'b1;
      end else begin
        case (phase)
          0: begin rst = 1'b0; flush = 1'b0; ready = 1'b1; end
          1: begin rst = 1'b0; flush = 1'b0; ready = ($urandom_range(7) == 0); end
          2: begin rst = 1'b0; flush = 1'b0; ready = c[0]; end
          default: begin
            rst   = ($urandom_range(49) == 0);
            flush = ($urandom_range(19) == 0);
            ready = ($urandom_range(1) == 0);
            force_empty = ($urandom_range(4) == 0);
          end
        endcase
      end
      empty = (src.size() == 0) || force_empty;
      if (c < 3) rdata = 8'hFF;
      else rdata = pend_v ? pend_d : DW'($urandom);
      #1;

      // Expected behaviour from the buffered-word model
      avail = 0;
      foreach (q[i]) if (q[i].t <= c - 2) avail++;
      exp_pop   = !rst && !flush && !empty && (q.size() < 3);
      exp_valid = !rst && !flush && (avail > 0);

      check("pop",   32'(pop),   32'(exp_pop));
      check("valid", 32'(valid), 32'(exp_valid));
      check("level", 32'(level), rst ? 32'd0 : 32'(avail));
      if (rst) check("data_rst", 32'(data), 32'd0);
      else if (exp_valid) check("data", 32'(data), 32'(q[0].d));

      pend_v = 1'b0;
      if (rst || flush) begin
        q.delete();
      end else begin
        if (exp_valid && ready) void'(q.pop_front());
        if (exp_pop) begin
          pend_v = 1'b1;
          pend_d = src.pop_front();
          q.push_back('{d: pend_d, t: c});
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
